// File: rtl/ic_sweep_ctrl.sv
// ic_sweep_ctrl: sequencer that exhaustively checks a combinational
// bvashr/bvslt invertibility-condition function
//   IC(s, t) = exists x : (s >>>a x) <s t
// Every (s, t) pair is driven onto ic_s/ic_t. The ground truth is found by
// walking all shift amounts x, then compared against ic_val.
//
// Optional feature macro: SWEEP_STOP_ON_FAIL_EN
//   defined   -> the sweep ends at the first mismatching pair
//   undefined -> all pairs are swept and every mismatch is counted
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   start           begin a full sweep (honoured only in IDLE/DONE)
//   ic_s, ic_t      operands driven to the IC function
//   ic_val          IC function output, sampled in COMPARE
//   busy, done      sweep in progress / one-cycle end pulse
//   pair_cnt        pairs compared so far
//   mismatch_cnt    pairs where ic_val differed from the ground truth
//   first_fail_*    s, t and ground truth of the first mismatch
module ic_sweep_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     ic_s,
  output logic [WIDTH-1:0]     ic_t,
  input  logic                 ic_val,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     pair_cnt,
  output logic [2*WIDTH:0]     mismatch_cnt,
  output logic [WIDTH-1:0]     first_fail_s,
  output logic [WIDTH-1:0]     first_fail_t,
  output logic                 first_fail_exp
);

  localparam int unsigned CW = 2*WIDTH + 1;
  localparam logic [WIDTH-1:0] MAXV = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SEARCH  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   s;
  logic [WIDTH-1:0]   t;
  logic [WIDTH-1:0]   x;
  logic               found;

  logic signed [WIDTH-1:0] shifted_c;
  logic                    hit_c;
  logic                    mismatch_c;
  logic                    last_c;
  logic                    stop_c;

  // Witness test for the current x; shifts >= WIDTH fill with the sign bit.
  always_comb begin
    shifted_c  = $signed(s) >>> x;
    hit_c      = shifted_c < $signed(t);
    mismatch_c = (ic_val != found);
    last_c     = (s == MAXV) && (t == MAXV);
`ifdef SWEEP_STOP_ON_FAIL_EN
    stop_c     = mismatch_c;
`else
    stop_c     = 1'b0;
`endif
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      s              <= '0;
      t              <= '0;
      x              <= '0;
      found          <= 1'b0;
      ic_s           <= '0;
      ic_t           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pair_cnt       <= '0;
      mismatch_cnt   <= '0;
      first_fail_s   <= '0;
      first_fail_t   <= '0;
      first_fail_exp <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pair_cnt       <= '0;
            mismatch_cnt   <= '0;
            first_fail_s   <= '0;
            first_fail_t   <= '0;
            first_fail_exp <= 1'b0;
            s              <= '0;
            t              <= '0;
            busy           <= 1'b1;
            state          <= APPLY;
          end
        end
        APPLY: begin
          ic_s  <= s;
          ic_t  <= t;
          x     <= '0;
          found <= 1'b0;
          state <= SEARCH;
        end
        SEARCH: begin
          if (hit_c) begin
            found <= 1'b1;
            state <= COMPARE;
          end else if (x == MAXV) begin
            state <= COMPARE;
          end else begin
            x <= x + WIDTH'(1);
          end
        end
        COMPARE: begin
          pair_cnt <= pair_cnt + CW'(1);
          if (mismatch_c) begin
            mismatch_cnt <= mismatch_cnt + CW'(1);
            if (mismatch_cnt == '0) begin
              first_fail_s   <= s;
              first_fail_t   <= t;
              first_fail_exp <= found;
            end
          end
          if (last_c || stop_c) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            // t is the inner loop; s advances when t wraps.
            t <= t + WIDTH'(1);
            if (t == MAXV) s <= s + WIDTH'(1);
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
